down_counter: RTL
=================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, 8, count and load width, SHALL be supported for values 2..16.
REQ-003 Parameter PS_WIDTH, 8, prescale width, SHALL be supported for values 1..16.
REQ-004 Port clk  in  1  SHALL be the rising-edge clock.
REQ-005 Port rst  in  1  SHALL be the synchronous active-high reset.
REQ-006 Port load_valid  in  1  SHALL request a load of load_value.
REQ-007 Port load_ready  out  1  SHALL indicate a load is accepted this cycle.
REQ-008 Port load_value  in  WIDTH  SHALL be the start count and reload value.
REQ-009 Port load_auto  in  1  SHALL select periodic mode (1) or one-shot mode (0), sampled with the load.
REQ-010 Port prescale  in  PS_WIDTH  SHALL set the tick period to prescale+1 clk cycles.
REQ-011 Port start  in  1  SHALL be a level-sampled request to start or resume counting.
REQ-012 Port stop  in  1  SHALL be a level-sampled request to pause counting.
REQ-013 Port out  out  WIDTH  SHALL be the registered current count.
REQ-014 Port tc  out  1  SHALL be the registered terminal-count pulse.
REQ-015 Port busy  out  1  SHALL be high exactly while in state RUN.

Function
REQ-016 States SHALL be IDLE, RUN and PAUSE, with registered state, out, tc, prescaler count ps_cnt, latched prescale ps_lat, reload register rld and mode bit.
REQ-017 load_ready SHALL be 1 in IDLE and PAUSE and 0 in RUN; a load is a cycle with load_valid && load_ready.
REQ-018 On a load: out <= load_value, rld <= load_value, mode <= load_auto, ps_cnt <= 0, next state IDLE.
REQ-019 Load SHALL take priority over start and stop in the same cycle.
REQ-020 IDLE + start + out!=0 + no load: ps_lat <= prescale, ps_cnt <= 0, next state RUN.
REQ-021 IDLE + start + out==0: the block SHALL ignore start and remain in IDLE.
REQ-022 RUN, each edge without stop: if ps_cnt==ps_lat then ps_cnt <= 0 and a tick occurs; else ps_cnt <= ps_cnt+1.
REQ-023 Tick with out>1: out <= out-1.
REQ-024 Tick with out==1, one-shot: out <= 0, tc <= 1, next state IDLE.
REQ-025 Tick with out==1, periodic: out <= rld, tc <= 1, state stays RUN; out SHALL never show 0.
REQ-026 tc SHALL be high for exactly one cycle per expiry and 0 in all other cycles.
REQ-027 First tick after a start accepted at edge k SHALL occur at edge k+ps_lat+1.
REQ-028 RUN + stop: next state PAUSE; out, ps_cnt and ps_lat SHALL hold; no tick on that edge.
REQ-029 RUN + start + stop in the same cycle: stop SHALL win.
REQ-030 PAUSE + start without stop: next state RUN, resuming with ps_cnt and out unchanged; prescale is not re-sampled.
REQ-031 prescale changes while in RUN or PAUSE SHALL have no effect until the next start from IDLE.
REQ-032 All arithmetic SHALL be unsigned, WIDTH and PS_WIDTH bits, with no out underflow below 0.

Reset
REQ-033 Reset SHALL force state IDLE, out=0, tc=0, ps_cnt=0, ps_lat=0, rld=0, mode=0, busy=0, load_ready=1.
REQ-034 Reset SHALL override every other input, including mid-RUN and during a tick or load cycle.

Verification
REQ-035 Reset: assert rst 2 cycles -> out=0, tc=0, busy=0, load_ready=1.
REQ-036 Load 5 one-shot, prescale=0, start -> out 5,4,3,2,1,0 on consecutive edges; tc=1 only in the cycle out=0; then busy=0.
REQ-037 Load 3 periodic, prescale=2, start -> out steps 3,2,1,3,2,1 every 3 cycles; tc pulses every 9 cycles; out never 0.
REQ-038 Load 10, prescale=3, start, stop after 6 cycles, hold 20 cycles, start -> out frozen at 9 during PAUSE; the next decrement occurs after the remaining prescale cycles; expiry lands 20 cycles later than without the pause.
REQ-039 start with out=0 -> stays IDLE, busy=0; load_valid during RUN -> load_ready=0 and out unaffected; load+start same cycle -> loaded, state IDLE.
REQ-040 rst asserted mid-RUN, on the tick edge with out==1 -> out=0, tc=0, state IDLE the next cycle.

Source files
------------

// File: rtl/down_counter_if.sv
// Load/control/status bundle for down_counter. The master side drives
// load and run requests, and the slave side (the counter) reports its status.
interface down_counter_if #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 8
);
  logic                load_valid;
  logic                load_ready;
  logic [WIDTH-1:0]    load_value;
  logic                load_auto;
  logic [PS_WIDTH-1:0] prescale;
  logic                start;
  logic                stop;
  logic [WIDTH-1:0]    out;
  logic                tc;
  logic                busy;

  modport master (
    output load_valid, load_value, load_auto, prescale, start, stop,
    input  load_ready, out, tc, busy
  );

  modport slave (
    input  load_valid, load_value, load_auto, prescale, start, stop,
    output load_ready, out, tc, busy
  );
endinterface

// File: rtl/down_counter.sv
// Prescaled down counter with one-shot/periodic reload, pause/resume and a
// single-cycle terminal-count pulse.
module down_counter #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    rld;
  logic                mode;
  logic                tc_r;
  logic [PS_WIDTH-1:0] ps_cnt;
  logic [PS_WIDTH-1:0] ps_lat;
  logic                load;
  logic                tick;

  assign bus.load_ready = (state != RUN);
  assign bus.busy       = (state == RUN);
  assign bus.out        = cnt;
  assign bus.tc         = tc_r;

  // Loads are only accepted outside RUN, so load priority needs no extra gating.
  assign load = bus.load_valid && (state != RUN);
  assign tick = (state == RUN) && !bus.stop && (ps_cnt == ps_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rld    <= '0;
      mode   <= 1'b0;
      tc_r   <= 1'b0;
      ps_cnt <= '0;
      ps_lat <= '0;
    end else begin
      tc_r <= 1'b0;
      if (load) begin
        cnt    <= bus.load_value;
        rld    <= bus.load_value;
        mode   <= bus.load_auto;
        ps_cnt <= '0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && (cnt != '0)) begin
              ps_lat <= bus.prescale;
              ps_cnt <= '0;
              state  <= RUN;
            end
          end
          RUN: begin
            if (bus.stop) begin
              state <= PAUSE;
            end else if (tick) begin
              ps_cnt <= '0;
              if (cnt > WIDTH'(1)) begin
                cnt <= cnt - WIDTH'(1);
              end else if (mode) begin
                // Periodic expiry reloads directly, so out never shows zero.
                cnt  <= rld;
                tc_r <= 1'b1;
              end else begin
                cnt   <= '0;
                tc_r  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              ps_cnt <= ps_cnt + PS_WIDTH'(1);
            end
          end
          PAUSE: begin
            if (bus.start && !bus.stop) begin
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
